// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq -- iterative unsigned shift-add multiplier for the Beta ALU MUL.
//
// One WIDTH-bit ripple adder built from full_adder cells is reused once per
// cycle to accumulate partial products, LSB of the multiplier first. A result
// is ready WIDTH+1 cycles after start is accepted. The low WIDTH bits of the
// product are also the two's-complement signed product.
//
// Ports (alu_mul_seq):
//   clk      in   1        rising-edge clock
//   reset    in   1        synchronous, active-high reset
//   start    in   1        request; a and b are sampled when accepted
//   a        in   WIDTH    multiplicand (unsigned)
//   b        in   WIDTH    multiplier (unsigned)
//   busy     out  1        high while iterating
//   done     out  1        one-cycle pulse; product valid in this cycle
//   product  out  2*WIDTH  {hi,lo} result; held until the next result
//
// Ports (full_adder):
//   i_a, i_b, i_cin  in   1   addend bits and carry in
//   o_sum, o_cout    out  1   sum bit and carry out
// ---------------------------------------------------------------------------

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module alu_mul_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mq;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH:0]     w_carry;
    logic [2*WIDTH-1:0] w_next;
    logic               w_last;

    // Partial product for this step: the multiplicand if the current
    // multiplier LSB is set, otherwise nothing.
    assign w_addend   = r_mq[0] ? r_mcand : '0;
    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        full_adder u_fa (
            .i_a    (r_acc[i]),
            .i_b    (w_addend[i]),
            .i_cin  (w_carry[i]),
            .o_sum  (w_sum[i]),
            .o_cout (w_carry[i+1])
        );
    end

    // {carry, sum, mq} shifted right by one. The carry out of the adder is
    // the WIDTH+1-th accumulator bit; it only exists for one cycle because
    // the shift immediately moves it into the top of the stored accumulator.
    // The bit shifted out of mq (already consumed) is dropped.
    assign w_next = {w_carry[WIDTH], w_sum, r_mq[WIDTH-1:1]};
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // NOTE: all state uses non-blocking assignments so every register sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: reset is synchronous, so it is just the highest-priority
            // branch of the clocked block; no reset term in the sensitivity list.
            r_state <= S_IDLE;
            r_mcand <= '0;
            r_mq    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_mcand <= a;
                        r_mq    <= b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // start is deliberately ignored here: no queueing.
                    {r_acc, r_mq} <= w_next;
                    r_cnt         <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= w_next;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule
